// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: fetch state encoding and PC constants shared with decode and branch units
package if_fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;
  localparam logic [31:0] INST_STEP = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: ROM port, downstream instruction port and redirect/stall controls of the fetch unit
interface if_fetch_if #(
  parameter int ADDR = 32,
  parameter int WORD = 32
);
  import if_fetch_pkg::*;
  logic [ADDR-1:0] rom_addr_o;
  logic [WORD-1:0] rom_data_i;
  logic            stall_i;
  logic            redirect_i;
  logic [ADDR-1:0] redirect_pc_i;
  logic [WORD-1:0] inst_o;
  logic [ADDR-1:0] pc_o;
  logic            valid_o;
  logic [31:0]     fetch_cnt_o;
  modport master (
    output rom_addr_o, inst_o, pc_o, valid_o, fetch_cnt_o,
    input  rom_data_i, stall_i, redirect_i, redirect_pc_i
  );
  modport slave (
    input  rom_addr_o, inst_o, pc_o, valid_o, fetch_cnt_o,
    output rom_data_i, stall_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: one-cycle-latency instruction fetch with stall hold (ROM re-read) and zero-bubble redirect
module if_fetch import if_fetch_pkg::*; #(
  parameter int ADDR = 32,
  parameter int WORD = 32,
  parameter logic [ADDR-1:0] RESET_PC = ADDR'(RESET_PC_DEF)
) (
  input logic clk,
  input logic rst_n,
  if_fetch_if.master bus
);
  state_t          state;
  logic [ADDR-1:0] fetch_pc, resp_pc, redir_pc, rom_addr;
  logic [WORD-1:0] inst;
  logic [31:0]     fetch_cnt;
  logic            hold, accept;
  assign redir_pc = {bus.redirect_pc_i[ADDR-1:2], 2'b00};
  assign hold     = state != BOOT && bus.stall_i;
  assign rom_addr = bus.redirect_i ? redir_pc : hold ? resp_pc : fetch_pc;
  assign accept   = state != BOOT && !bus.stall_i && !bus.redirect_i;
  assign inst     = bus.rom_data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= BOOT;
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      fetch_cnt <= '0;
    end else begin
      state     <= hold && !bus.redirect_i ? STALL : RUN;
      resp_pc   <= rom_addr;
      fetch_pc  <= hold && !bus.redirect_i ? fetch_pc : rom_addr + ADDR'(INST_STEP);
      fetch_cnt <= fetch_cnt + 32'(accept);
    end
  assign bus.rom_addr_o  = rom_addr;
  assign bus.inst_o      = inst;
  assign bus.pc_o        = resp_pc;
  assign bus.valid_o     = state != BOOT;
  assign bus.fetch_cnt_o = fetch_cnt;
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 Parameter ADDR, default 32, meaning the PC and ROM address width.
REQ-003 Parameter WORD, default 32, meaning the instruction width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rom_addr_o  output  ADDR  byte address to the instruction ROM, which returns data one cycle later.
REQ-007 rom_data_i  input  WORD  ROM read data for the address presented in the previous cycle.
REQ-008 stall_i  input  1  downstream not accepting; hold the current instruction.
REQ-009 redirect_i  input  1  branch/jump taken; restart fetch at redirect_pc_i.
REQ-010 redirect_pc_i  input  ADDR  redirect target; bits [1:0] ignored and treated as zero.
REQ-011 inst_o  output  WORD  fetched instruction; equals rom_data_i, no extra register.
REQ-012 pc_o  output  ADDR  byte address of inst_o.
REQ-013 valid_o  output  1  inst_o/pc_o are meaningful.
REQ-014 fetch_cnt_o  output  32  count of instructions accepted downstream.

Function
REQ-015 Registers: fetch_pc (next address to issue), resp_pc (address of the in-flight response), state.
REQ-016 States: BOOT (no response in flight), RUN (response valid, advancing), STALL (response valid, held).
REQ-017 rom_addr_o mux, priority order: redirect_i -> {redirect_pc_i[ADDR-1:2],2'b00}; else state!=BOOT and stall_i -> resp_pc; else fetch_pc.
REQ-018 Each rising edge: resp_pc <= rom_addr_o; the ROM re-reads resp_pc during a stall, so no data buffer is needed.
REQ-019 fetch_pc update: redirect -> redirect target + 4; stall with valid response -> hold; otherwise -> rom_addr_o + 4.
REQ-020 All PC arithmetic is modulo 2^ADDR; 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
REQ-021 Transitions: BOOT -> RUN unconditionally. RUN -> STALL on stall_i without redirect_i. STALL -> RUN when stall_i is low or redirect_i is high. Redirect in any state -> RUN.
REQ-022 valid_o = (state != BOOT); pc_o = resp_pc.
REQ-023 Redirect has priority over stall in the same cycle. The instruction presented in the redirect cycle is not counted. The next cycle presents the target instruction with valid_o=1 (zero bubble).
REQ-024 Acceptance = valid_o & ~stall_i & ~redirect_i. fetch_cnt_o increments by 1 per acceptance and wraps at 2^32.
REQ-025 Sequential fetch latency: address issued in cycle N appears on inst_o/pc_o in cycle N+1.

Reset
REQ-026 On rst_n low, asynchronously set state=BOOT, fetch_pc=RESET_PC, resp_pc=RESET_PC, fetch_cnt=0.
REQ-027 During reset and in BOOT: rom_addr_o=RESET_PC, valid_o=0, pc_o=RESET_PC.
REQ-028 Reset asserted mid-stall or mid-redirect discards all in-flight state. No acceptance is counted in the reset cycle.
REQ-029 Release of rst_n is assumed synchronised externally. The first edge after release moves BOOT -> RUN.

Structure
REQ-030 Shared package holds the state enumeration (BOOT, RUN, STALL), the instruction-step constant 4 and the RESET_PC default, reused by the decode and branch units.
REQ-031 Single flat module with no sub-modules. The ROM is instantiated alongside if_fetch at the core top level, not inside it.

Verification
REQ-032 Reset release with ROM preloaded with words W0,W1,W2 at 0x0,0x4,0x8 -> cycle 1 valid_o=1, pc_o=0x0, inst_o=W0; cycle 2 pc_o=0x4, inst_o=W1; cycle 3 pc_o=0x8, inst_o=W2.
REQ-033 stall_i held high for 3 cycles while pc_o=0x4 -> pc_o=0x4 and inst_o=W1 stable for 3 cycles with fetch_cnt_o unchanged; first cycle after release shows pc_o=0x8.
REQ-034 redirect_i with redirect_pc_i=0x103 while stall_i=1 -> rom_addr_o=0x100 that cycle; next cycle pc_o=0x100, valid_o=1; following cycle pc_o=0x104.
REQ-035 Redirect to 0xFFFF_FFFC, no stall -> pc_o sequence 0xFFFF_FFFC then 0x0000_0000.
REQ-036 rst_n pulsed low mid-stream at pc_o=0x20 -> valid_o=0 immediately (asynchronous), fetch_cnt_o=0, rom_addr_o=RESET_PC; restart matches REQ-032.
REQ-037 10 cycles running free with no stall and no redirect -> fetch_cnt_o=10.
